// File: rtl/t07_top_core.sv
// t07_top_core: single-cycle execution core for the ESP instruction stream.
// Every rising edge one 32-bit word from ESP_in is decoded, its operands are
// read combinationally from a 16-entry register file, and the result is
// written back on that same edge. Integer ALU ops and IEEE-754
// single-precision sign/compare ops are supported. NaN operands to the
// compare ops raise FPUFlag for one cycle; opcode 15 sets the sticky
// invalError.
module t07_top_core #(
  parameter int NREGS = 16,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [XLEN-1:0] ESP_in,
  output logic            FPUFlag,
  output logic            invalError
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LUI   = 4'd1,
    OP_ORI   = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_SLT   = 4'd8,
    OP_FNEG  = 4'd9,
    OP_FABS  = 4'd10,
    OP_FMIN  = 4'd11,
    OP_FMAX  = 4'd12,
    OP_FEQ   = 4'd13,
    OP_FLT   = 4'd14,
    OP_ILLEG = 4'd15
  } op_e;

  localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] SIGN_MASK  = 32'h8000_0000;

  // NaN: all-ones exponent with a nonzero mantissa (quiet or signalling).
  function automatic logic fp_is_nan(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
  endfunction

  // Both operands are zeros of either sign.
  function automatic logic fp_both_zero(input logic [31:0] a, input logic [31:0] b);
    return (a[30:0] == 31'h0) && (b[30:0] == 31'h0);
  endfunction

  // Sign-magnitude total order used by FMIN/FMAX: -0 sorts below +0.
  function automatic logic fp_order_lt(input logic [31:0] a, input logic [31:0] b);
    logic r;
    if (a[31] != b[31])
      r = a[31];
    else if (!a[31])
      r = (a[30:0] < b[30:0]);
    else
      r = (a[30:0] > b[30:0]);
    return r;
  endfunction

  // IEEE less-than for FLT: identical to the total order except that the
  // two zeros compare equal.
  function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
    return fp_both_zero(a, b) ? 1'b0 : fp_order_lt(a, b);
  endfunction

  // IEEE equality for FEQ: bitwise equal, or +0 against -0.
  function automatic logic fp_eq(input logic [31:0] a, input logic [31:0] b);
    return (a == b) || fp_both_zero(a, b);
  endfunction

  // Architectural state.
  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_fpu_flag;
  logic            r_inval_err;

  // Instruction fields.
  op_e                w_op;
  logic [3:0]         w_rd;
  logic [3:0]         w_rs1_idx;
  logic [3:0]         w_rs2_idx;
  logic [15:0]        w_imm;
  logic [XLEN-1:0]    w_rs1;
  logic [XLEN-1:0]    w_rs2;
  logic signed [XLEN-1:0] w_rs1_s;
  logic signed [XLEN-1:0] w_rs2_s;
  logic               w_any_nan;

  // Execute results.
  logic [XLEN-1:0]    w_result;
  logic               w_we;
  logic               w_wr_en;
  logic               w_nan_evt;
  logic               w_illegal;

  assign w_op      = op_e'(ESP_in[31:28]);
  assign w_rd      = ESP_in[27:24];
  assign w_rs1_idx = ESP_in[23:20];
  assign w_rs2_idx = ESP_in[19:16];
  assign w_imm     = ESP_in[15:0];

  // x0 is forced to read zero regardless of the array contents.
  assign w_rs1   = (w_rs1_idx == 4'd0) ? '0 : r_regs[w_rs1_idx];
  assign w_rs2   = (w_rs2_idx == 4'd0) ? '0 : r_regs[w_rs2_idx];
  assign w_rs1_s = w_rs1;
  assign w_rs2_s = w_rs2;

  assign w_any_nan = fp_is_nan(w_rs1) || fp_is_nan(w_rs2);

  // Writes to x0 are dropped here so the register file never changes it.
  assign w_wr_en = w_we && (w_rd != 4'd0);

  // Decode and execute the current instruction word.
  always_comb begin
    w_result  = '0;
    w_we      = 1'b0;
    w_nan_evt = 1'b0;
    w_illegal = 1'b0;
    case (w_op)
      OP_NOP: begin
        w_we = 1'b0;
      end
      OP_LUI: begin
        w_we     = 1'b1;
        w_result = {w_imm, 16'h0000};
      end
      OP_ORI: begin
        w_we     = 1'b1;
        w_result = w_rs1 | {16'h0000, w_imm};
      end
      OP_ADD: begin
        w_we     = 1'b1;
        w_result = w_rs1 + w_rs2;
      end
      OP_SUB: begin
        w_we     = 1'b1;
        w_result = w_rs1 - w_rs2;
      end
      OP_AND: begin
        w_we     = 1'b1;
        w_result = w_rs1 & w_rs2;
      end
      OP_OR: begin
        w_we     = 1'b1;
        w_result = w_rs1 | w_rs2;
      end
      OP_XOR: begin
        w_we     = 1'b1;
        w_result = w_rs1 ^ w_rs2;
      end
      OP_SLT: begin
        w_we     = 1'b1;
        w_result = (w_rs1_s < w_rs2_s) ? 32'd1 : 32'd0;
      end
      OP_FNEG: begin
        // Pure sign manipulation: NaN inputs pass through unflagged.
        w_we     = 1'b1;
        w_result = w_rs1 ^ SIGN_MASK;
      end
      OP_FABS: begin
        w_we     = 1'b1;
        w_result = w_rs1 & ~SIGN_MASK;
      end
      OP_FMIN: begin
        w_we      = 1'b1;
        w_nan_evt = w_any_nan;
        if (w_any_nan)
          w_result = CANON_QNAN;
        else
          w_result = fp_order_lt(w_rs1, w_rs2) ? w_rs1 : w_rs2;
      end
      OP_FMAX: begin
        w_we      = 1'b1;
        w_nan_evt = w_any_nan;
        if (w_any_nan)
          w_result = CANON_QNAN;
        else
          w_result = fp_order_lt(w_rs1, w_rs2) ? w_rs2 : w_rs1;
      end
      OP_FEQ: begin
        w_we      = 1'b1;
        w_nan_evt = w_any_nan;
        w_result  = (!w_any_nan && fp_eq(w_rs1, w_rs2)) ? 32'd1 : 32'd0;
      end
      OP_FLT: begin
        w_we      = 1'b1;
        w_nan_evt = w_any_nan;
        w_result  = (!w_any_nan && fp_lt(w_rs1, w_rs2)) ? 32'd1 : 32'd0;
      end
      default: begin
        // Opcode 15: no write-back, only the sticky error.
        w_illegal = 1'b1;
      end
    endcase
  end

  // Write-back and status flags; reset clears everything and drops the
  // instruction sampled on that edge.
  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
      r_fpu_flag  <= 1'b0;
      r_inval_err <= 1'b0;
    end else begin
      if (w_wr_en)
        r_regs[w_rd] <= w_result;
      r_fpu_flag <= w_nan_evt;
      if (w_illegal)
        r_inval_err <= 1'b1;
    end
  end

  assign FPUFlag    = r_fpu_flag;
  assign invalError = r_inval_err;

endmodule

// File: tb/tb_t07_top_core.sv
// Directed bench for t07_top_core: a table of single-instruction vectors
// with hand-computed register results and flags, plus hand-written
// sequences for reset, the NOP stream, illegal opcodes and mid-stream reset.
module tb_t07_top_core;

  logic        clk;
  logic        nrst;
  logic [31:0] ESP_in;
  logic        FPUFlag;
  logic        invalError;

  int n_checks = 0;
  int n_errors = 0;

  t07_top_core #(.NREGS(16), .XLEN(32)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .ESP_in     (ESP_in),
    .FPUFlag    (FPUFlag),
    .invalError (invalError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          chk_reg;
    logic [31:0] exp_val;
    logic        exp_fpu;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic void add(input string nm, input logic [31:0] ins, input int r,
                              input logic [31:0] v, input logic f);
    vec_t e;
    e.name = nm; e.instr = ins; e.chk_reg = r; e.exp_val = v; e.exp_fpu = f;
    vecs.push_back(e);
  endfunction

  function automatic logic [31:0] reg_rd(input int i);
    return dut.r_regs[i];
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Present one word for one rising edge, then settle past the edge.
  task automatic step(input logic [31:0] w);
    @(negedge clk);
    ESP_in = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst   = 1'b1;
    ESP_in = 32'h0;

    // Integer sequence
    add("lui_x1",   enc(1, 1, 0, 0, 16'h0001), 1, 32'h0001_0000, 0);
    add("ori_x1",   enc(2, 1, 1, 0, 16'h0002), 1, 32'h0001_0002, 0);
    add("lui_x2",   enc(1, 2, 0, 0, 16'h0000), 2, 32'h0000_0000, 0);
    add("ori_x2",   enc(2, 2, 2, 0, 16'h0005), 2, 32'h0000_0005, 0);
    add("add_x3",   enc(3, 3, 1, 2, 16'h0),    3, 32'h0001_0007, 0);
    add("sub_x4",   enc(4, 4, 2, 1, 16'h0),    4, 32'hFFFF_0003, 0);
    add("slt_x5",   enc(8, 5, 4, 2, 16'h0),    5, 32'h0000_0001, 0);
    add("add_x0",   enc(3, 0, 1, 2, 16'h0),    0, 32'h0000_0000, 0);
    add("and_x6",   enc(5, 6, 1, 3, 16'h0),    6, 32'h0001_0002, 0);
    add("or_x7",    enc(6, 7, 1, 2, 16'h0),    7, 32'h0001_0007, 0);
    add("xor_x8",   enc(7, 8, 1, 3, 16'h0),    8, 32'h0000_0005, 0);
    add("slt_x9",   enc(8, 9, 2, 4, 16'h0),    9, 32'h0000_0000, 0);
    add("nop_keep", 32'h0,                      3, 32'h0001_0007, 0);
    // FP compare: x1=1.0, x2=-2.0
    add("lui_1p0",  enc(1, 1, 0, 0, 16'h3F80), 1, 32'h3F80_0000, 0);
    add("lui_m2p0", enc(1, 2, 0, 0, 16'hC000), 2, 32'hC000_0000, 0);
    add("fmin",     enc(11, 3, 1, 2, 16'h0),   3, 32'hC000_0000, 0);
    add("fmax",     enc(12, 4, 1, 2, 16'h0),   4, 32'h3F80_0000, 0);
    add("flt_21",   enc(14, 5, 2, 1, 16'h0),   5, 32'h0000_0001, 0);
    add("feq_12",   enc(13, 6, 1, 2, 16'h0),   6, 32'h0000_0000, 0);
    add("flt_12",   enc(14, 7, 1, 2, 16'h0),   7, 32'h0000_0000, 0);
    add("feq_11",   enc(13, 8, 1, 1, 16'h0),   8, 32'h0000_0001, 0);
    // Zeros: x1=+0, x2=-0
    add("lui_p0",   enc(1, 1, 0, 0, 16'h0000), 1, 32'h0000_0000, 0);
    add("lui_m0",   enc(1, 2, 0, 0, 16'h8000), 2, 32'h8000_0000, 0);
    add("feq_z",    enc(13, 3, 1, 2, 16'h0),   3, 32'h0000_0001, 0);
    add("flt_z",    enc(14, 4, 2, 1, 16'h0),   4, 32'h0000_0000, 0);
    add("fmin_z",   enc(11, 5, 1, 2, 16'h0),   5, 32'h8000_0000, 0);
    add("fmax_z",   enc(12, 8, 1, 2, 16'h0),   8, 32'h0000_0000, 0);
    add("fmin_z21", enc(11, 7, 2, 1, 16'h0),   7, 32'h8000_0000, 0);
    add("fmax_z21", enc(12, 3, 2, 1, 16'h0),   3, 32'h0000_0000, 0);
    // Negatives: x1=-1.0 against x2=-0, then x2=-2.0
    add("lui_m1p0", enc(1, 1, 0, 0, 16'hBF80), 1, 32'hBF80_0000, 0);
    add("fmin_m1z", enc(11, 4, 1, 2, 16'h0),   4, 32'hBF80_0000, 0);
    add("flt_m1z",  enc(14, 5, 1, 2, 16'h0),   5, 32'h0000_0001, 0);
    add("lui_m2b",  enc(1, 2, 0, 0, 16'hC000), 2, 32'hC000_0000, 0);
    add("flt_negs", enc(14, 6, 2, 1, 16'h0),   6, 32'h0000_0001, 0);
    add("fmax_neg", enc(12, 7, 1, 2, 16'h0),   7, 32'hBF80_0000, 0);
    add("fmin_neg", enc(11, 8, 1, 2, 16'h0),   8, 32'hC000_0000, 0);
    // Infinity is ordered, not NaN
    add("lui_inf",  enc(1, 1, 0, 0, 16'h7F80), 1, 32'h7F80_0000, 0);
    add("fmax_inf", enc(12, 3, 1, 2, 16'h0),   3, 32'h7F80_0000, 0);
    add("flt_inf",  enc(14, 4, 2, 1, 16'h0),   4, 32'h0000_0001, 0);
    // Smallest denormal above +0
    add("lui_den",  enc(1, 1, 0, 0, 16'h0000), 1, 32'h0000_0000, 0);
    add("ori_den",  enc(2, 1, 1, 0, 16'h0001), 1, 32'h0000_0001, 0);
    add("flt_den",  enc(14, 9, 0, 1, 16'h0),   9, 32'h0000_0001, 0);
    // NaN handling
    add("lui_nan",  enc(1, 1, 0, 0, 16'h7FC0), 1, 32'h7FC0_0000, 0);
    add("ori_nan",  enc(2, 1, 1, 0, 16'h0001), 1, 32'h7FC0_0001, 0);
    add("fmax_nan", enc(12, 3, 1, 2, 16'h0),   3, 32'h7FC0_0000, 1);
    add("fneg_nan", enc(9, 4, 1, 0, 16'h0),    4, 32'hFFC0_0001, 0);
    add("flt_nan",  enc(14, 5, 2, 1, 16'h0),   5, 32'h0000_0000, 1);
    add("feq_nan",  enc(13, 6, 1, 1, 16'h0),   6, 32'h0000_0000, 1);
    add("fmin_nan", enc(11, 7, 2, 1, 16'h0),   7, 32'h7FC0_0000, 1);
    add("nop_clr",  32'h0,                      7, 32'h7FC0_0000, 0);
    add("fabs",     enc(10, 8, 2, 0, 16'h0),   8, 32'h4000_0000, 0);
    add("lui_snan", enc(1, 1, 0, 0, 16'h7F80), 1, 32'h7F80_0000, 0);
    add("ori_snan", enc(2, 1, 1, 0, 16'h0001), 1, 32'h7F80_0001, 0);
    add("feq_snan", enc(13, 9, 1, 1, 16'h0),   9, 32'h0000_0000, 1);
    add("fmin_ok",  enc(11, 3, 2, 0, 16'h0),   3, 32'hC000_0000, 0);
    add("fmax_snan",enc(12, 3, 1, 2, 16'h0),   3, 32'h7FC0_0000, 1);

    // Reset held for two edges
    @(posedge clk);
    @(posedge clk);
    #1;
    chk1("rst_fpu", FPUFlag, 1'b0);
    chk1("rst_inval", invalError, 1'b0);
    for (int i = 0; i < 16; i++)
      chk32($sformatf("rst_x%0d", i), reg_rd(i), 32'h0);
    @(negedge clk);
    nrst = 1'b0;

    // 70-cycle NOP stream
    for (int c = 0; c < 70; c++) begin
      step(32'h0);
      chk1($sformatf("nop%0d_fpu", c), FPUFlag, 1'b0);
      chk1($sformatf("nop%0d_inval", c), invalError, 1'b0);
    end

    // Table-driven vectors
    foreach (vecs[k]) begin
      step(vecs[k].instr);
      chk32({vecs[k].name, "_reg"}, reg_rd(vecs[k].chk_reg), vecs[k].exp_val);
      chk1({vecs[k].name, "_fpu"}, FPUFlag, vecs[k].exp_fpu);
      chk1({vecs[k].name, "_inval"}, invalError, 1'b0);
    end

    // Illegal opcode: sticky error, no write-back, execution continues
    step(32'hF000_0000);
    chk1("ill_inval", invalError, 1'b1);
    chk1("ill_fpu", FPUFlag, 1'b1 ^ 1'b1);
    step(enc(15, 3, 1, 2, 16'h1234));
    chk32("ill_nowrite_x3", reg_rd(3), 32'h7FC0_0000);
    chk1("ill2_inval", invalError, 1'b1);
    step(enc(3, 9, 2, 2, 16'h0));
    chk32("add_after_ill", reg_rd(9), 32'h8000_0000);
    chk1("add_after_ill_inval", invalError, 1'b1);
    step(32'h0);
    chk1("nop_after_ill_inval", invalError, 1'b1);

    // Raise FPUFlag, then reset mid-stream with a NaN op and a LUI pending
    step(enc(12, 3, 1, 2, 16'h0));
    chk1("pre_rst_fpu", FPUFlag, 1'b1);
    @(negedge clk);
    nrst   = 1'b1;
    ESP_in = enc(12, 10, 1, 2, 16'h0);
    @(posedge clk);
    #1;
    chk1("mrst_fpu", FPUFlag, 1'b0);
    chk1("mrst_inval", invalError, 1'b0);
    for (int i = 0; i < 16; i++)
      chk32($sformatf("mrst_x%0d", i), reg_rd(i), 32'h0);
    @(negedge clk);
    nrst   = 1'b0;
    ESP_in = 32'h0;
    step(enc(1, 10, 0, 0, 16'hABCD));
    chk32("post_rst_lui", reg_rd(10), 32'hABCD_0000);
    chk1("post_rst_inval", invalError, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
